// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the divider request scheduler.
package div_sched_pkg;

    // Widest operand the overflow helper can examine.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic dz;
        logic ovf;
        logic tmo;
    } flags_t;

    // True when num is the most-negative value of the given width and den is -1.
    // Operands are zero-extended to MAX_W and only the low 'width' bits are examined.
    function automatic logic is_ovf(input logic [MAX_W-1:0] num,
                                    input logic [MAX_W-1:0] den,
                                    input int               width);
        logic num_min;
        logic den_neg1;
        num_min  = 1'b1;
        den_neg1 = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                if (i == width - 1) begin
                    if (!num[i]) num_min = 1'b0;
                end else begin
                    if (num[i]) num_min = 1'b0;
                end
                if (!den[i]) den_neg1 = 1'b0;
            end
        end
        return num_min && den_neg1;
    endfunction

endpackage

// File: rtl/div_sched_fifo.sv
// Request FIFO holding {num, den} pairs. The pointers carry one extra wrap bit
// so that full and empty are told apart without a separate flag.
module div_sched_fifo
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Scheduler in front of the iterative divider: queues signed requests, issues one at a
// time with a start pulse, collects the quotient/remainder and returns them with flags.
// Zero denominators skip the divider; a watchdog bounds the wait for div_done.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int tamanyo    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          CLK,
    input  logic                          RSTa,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [tamanyo-1:0]            in_num,
    input  logic [tamanyo-1:0]            in_den,
    output logic                          div_start,
    output logic [tamanyo-1:0]            div_num,
    output logic [tamanyo-1:0]            div_den,
    input  logic [tamanyo-1:0]            div_coc,
    input  logic [tamanyo-1:0]            div_res,
    input  logic                          div_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [tamanyo-1:0]            out_coc,
    output logic [tamanyo-1:0]            out_res,
    output logic                          out_dz,
    output logic                          out_ovf,
    output logic                          out_tmo,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    flags_t                  flags;
    logic [CW-1:0]           wd_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [2*tamanyo-1:0]    head;
    logic [tamanyo-1:0]      head_num;
    logic [tamanyo-1:0]      head_den;
    logic                    push;
    logic                    pop;
    logic [LW-1:0]           level_next;
    logic                    active_next;
    logic                    busy_next;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !fifo_empty;
    assign head_num = head[2*tamanyo-1:tamanyo];
    assign head_den = head[tamanyo-1:0];
    assign out_dz   = flags.dz;
    assign out_ovf  = flags.ovf;
    assign out_tmo  = flags.tmo;

    div_sched_fifo #(
        .WIDTH (2 * tamanyo),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RSTa),
        .push    (push),
        .wr_data ({in_num, in_den}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Look ahead one cycle so busy can be registered: active next cycle or FIFO non-empty.
    always_comb begin
        level_next  = fifo_level;
        active_next = 1'b1;
        if (push && !pop) begin
            level_next = fifo_level + 1'b1;
        end else if (pop && !push) begin
            level_next = fifo_level - 1'b1;
        end
        case (state)
            IDLE:    active_next = pop;
            OUTPUT:  active_next = !out_ready;
            default: active_next = 1'b1;
        endcase
        busy_next = active_next || (level_next != '0);
    end

    // Scheduler FSM with registered divider controls, result registers and watchdog.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state     <= IDLE;
            div_start <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            out_coc   <= '0;
            out_res   <= '0;
            flags     <= '0;
            wd_cnt    <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= busy_next;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        div_num <= head_num;
                        div_den <= head_den;
                        if (head_den == '0) begin
                            out_coc   <= '1;
                            out_res   <= head_num;
                            flags     <= '{dz: 1'b1, ovf: 1'b0, tmo: 1'b0};
                            out_valid <= 1'b1;
                            state     <= OUTPUT;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (div_done) begin
                        out_coc   <= div_coc;
                        out_res   <= div_res;
                        flags     <= '{dz: 1'b0,
                                       ovf: is_ovf(MAX_W'(div_num), MAX_W'(div_den), tamanyo),
                                       tmo: 1'b0};
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        out_coc   <= '0;
                        out_res   <= '0;
                        flags     <= '{dz: 1'b0, ovf: 1'b0, tmo: 1'b1};
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched: table of directed divisions against a behavioural
// divider, plus hand-written sequences for timing, backpressure, watchdog and reset.
module tb_div_sched;

    localparam int W    = 32;
    localparam int DEP  = 4;
    localparam int TMO  = 20;
    localparam int LDIV = 3;

    logic          CLK = 1'b0;
    logic          RSTa;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_num;
    logic [W-1:0]  in_den;
    logic          div_start;
    logic [W-1:0]  div_num;
    logic [W-1:0]  div_den;
    logic [W-1:0]  div_coc;
    logic [W-1:0]  div_res;
    logic          div_done;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_coc;
    logic [W-1:0]  out_res;
    logic          out_dz;
    logic          out_ovf;
    logic          out_tmo;
    logic          busy;
    logic [2:0]    fifo_level;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Divider stand-in controls
    logic          stub;
    logic          force_done;
    logic [W-1:0]  force_coc;
    logic          m_done;
    logic          m_busy;
    int            m_cnt;
    logic [W-1:0]  m_coc;
    logic [W-1:0]  m_res;

    div_sched #(.tamanyo(W), .FIFO_DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RSTa       (RSTa),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_num     (in_num),
        .in_den     (in_den),
        .div_start  (div_start),
        .div_num    (div_num),
        .div_den    (div_den),
        .div_coc    (div_coc),
        .div_res    (div_res),
        .div_done   (div_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_coc    (out_coc),
        .out_res    (out_res),
        .out_dz     (out_dz),
        .out_ovf    (out_ovf),
        .out_tmo    (out_tmo),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] behQuo(input logic [W-1:0] a, input logic [W-1:0] b);
        longint n;
        longint d;
        n = longint'($signed(a));
        d = longint'($signed(b));
        return W'(n / d);
    endfunction

    function automatic logic [W-1:0] behRem(input logic [W-1:0] a, input logic [W-1:0] b);
        longint n;
        longint d;
        n = longint'($signed(a));
        d = longint'($signed(b));
        return W'(n % d);
    endfunction

    // Behavioural divider: done pulse LDIV cycles after start unless stubbed out.
    always @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_coc  <= '0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (div_start && !stub) begin
                m_busy <= 1'b1;
                m_cnt  <= LDIV;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_coc  <= behQuo(div_num, div_den);
                    m_res  <= behRem(div_num, div_den);
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_done = m_done | force_done;
    assign div_coc  = force_done ? force_coc : m_coc;
    assign div_res  = force_done ? '0 : m_res;

    // Count start pulses, sampled mid-cycle.
    always @(negedge CLK) begin
        if (div_start === 1'b1) start_cnt++;
    end

    // Hard stop if the bench ever wedges.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic         dz;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];
    vec_t bp[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready with in_valid already high, then drop in_valid after the push edge.
    task automatic finishPush();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: in_ready got %0b expected 1", in_ready);
        end else begin
            @(negedge CLK);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] num, input logic [W-1:0] den);
        in_num   = num;
        in_den   = den;
        in_valid = 1'b1;
        finishPush();
    endtask

    task automatic waitOutput(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait: out_valid got %0b expected 1", name, out_valid);
        end
    endtask

    task automatic acceptOutput();
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic waitStart();
        int n = 0;
        while (div_start !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("issue_start", div_start, 1);
    endtask

    initial begin
        int s0;
        logic seen;

        vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0};
        vecs[2] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 1'b0};
        vecs[3] = '{32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1'b0};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b1};
        vecs[5] = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 1'b0};

        bp[0] = '{32'd100,      32'd7, 32'd14,       32'd2,        1'b0, 1'b0};
        bp[1] = '{32'd50,       32'd5, 32'd10,       32'd0,        1'b0, 1'b0};
        bp[2] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        bp[3] = '{32'd9,        32'd4, 32'd2,        32'd1,        1'b0, 1'b0};
        bp[4] = '{32'd1,        32'd3, 32'd0,        32'd1,        1'b0, 1'b0};
        bp[5] = '{32'hFFFFFFF7, 32'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0};

        RSTa       = 1'b1;
        in_valid   = 1'b0;
        in_num     = '0;
        in_den     = '0;
        out_ready  = 1'b0;
        stub       = 1'b0;
        force_done = 1'b0;
        force_coc  = '0;
        repeat (2) @(negedge CLK);

        checkOutput("rst_in_ready",  in_ready,   1);
        checkOutput("rst_out_valid", out_valid,  0);
        checkOutput("rst_div_start", div_start,  0);
        checkOutput("rst_busy",      busy,       0);
        checkOutput("rst_level",     fifo_level, 0);
        checkOutput("rst_out_coc",   out_coc,    0);
        checkOutput("rst_div_num",   div_num,    0);
        checkOutput("rst_flags",     {out_dz, out_ovf, out_tmo}, 0);

        RSTa = 1'b0;
        @(negedge CLK);

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            s0 = start_cnt;
            applyStimulus(vecs[i].num, vecs[i].den);
            waitOutput($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_coc", i), out_coc, vecs[i].coc);
            checkOutput($sformatf("vec%0d_res", i), out_res, vecs[i].res);
            checkOutput($sformatf("vec%0d_dz", i),  out_dz,  vecs[i].dz);
            checkOutput($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].ovf);
            checkOutput($sformatf("vec%0d_tmo", i), out_tmo, 0);
            checkOutput($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].dz ? 0 : 1);
            acceptOutput();
        end

        $display("[TB] divide-by-zero timing");
        s0 = start_cnt;
        applyStimulus(32'd5, 32'd0);
        checkOutput("dz_early_valid", out_valid, 0);
        checkOutput("dz_busy", busy, 1);
        @(negedge CLK);
        checkOutput("dz_valid", out_valid, 1);
        checkOutput("dz_flag", out_dz, 1);
        checkOutput("dz_coc", out_coc, 32'hFFFFFFFF);
        checkOutput("dz_res", out_res, 5);
        acceptOutput();
        checkOutput("dz_no_start", start_cnt - s0, 0);
        checkOutput("dz_idle_busy", busy, 0);

        $display("[TB] backpressure and ordering");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bp[i].num, bp[i].den);
        end
        checkOutput("bp_level_full", fifo_level, 4);
        checkOutput("bp_in_ready", in_ready, 0);
        in_num   = bp[5].num;
        in_den   = bp[5].den;
        in_valid = 1'b1;
        repeat (10) @(negedge CLK);
        checkOutput("bp_held_valid", out_valid, 1);
        checkOutput("bp_held_level", fifo_level, 4);
        for (int i = 0; i < 6; i++) begin
            waitOutput($sformatf("bp%0d", i));
            checkOutput($sformatf("bp%0d_coc", i), out_coc, bp[i].coc);
            checkOutput($sformatf("bp%0d_res", i), out_res, bp[i].res);
            acceptOutput();
            if (i == 0) finishPush();
        end
        repeat (2) @(negedge CLK);
        checkOutput("bp_drained", {busy, fifo_level}, 0);

        $display("[TB] watchdog timeout");
        stub = 1'b1;
        applyStimulus(32'd20, 32'd3);
        waitStart();
        repeat (TMO) @(negedge CLK);
        checkOutput("tmo_early_valid", out_valid, 0);
        @(negedge CLK);
        checkOutput("tmo_valid", out_valid, 1);
        checkOutput("tmo_flag", out_tmo, 1);
        checkOutput("tmo_coc", out_coc, 0);
        checkOutput("tmo_res", out_res, 0);
        force_coc  = 32'd77;
        force_done = 1'b1;
        @(negedge CLK);
        force_done = 1'b0;
        checkOutput("tmo_late_done_coc", out_coc, 0);
        checkOutput("tmo_late_done_flag", out_tmo, 1);
        acceptOutput();
        force_done = 1'b1;
        @(negedge CLK);
        force_done = 1'b0;
        @(negedge CLK);
        checkOutput("tmo_idle_done_ignored", {out_valid, busy}, 0);

        $display("[TB] done coincides with timeout");
        applyStimulus(32'd9, 32'd3);
        waitStart();
        repeat (TMO) @(negedge CLK);
        force_coc  = 32'd42;
        force_done = 1'b1;
        @(negedge CLK);
        force_done = 1'b0;
        checkOutput("tie_valid", out_valid, 1);
        checkOutput("tie_tmo", out_tmo, 0);
        checkOutput("tie_coc", out_coc, 42);
        acceptOutput();

        $display("[TB] reset mid-operation");
        applyStimulus(32'd10, 32'd2);
        applyStimulus(32'd20, 32'd4);
        applyStimulus(32'd30, 32'd6);
        @(negedge CLK);
        checkOutput("mid_level", fifo_level, 2);
        checkOutput("mid_div_num", div_num, 10);
        #2 RSTa = 1'b1;
        #1;
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_ctrl", {out_valid, div_start, busy}, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_operands", {div_num, div_den}, 0);
        checkOutput("mid_rst_results", {out_coc, out_res}, 0);
        checkOutput("mid_rst_flags", {out_dz, out_ovf, out_tmo}, 0);
        @(negedge CLK);
        RSTa = 1'b0;
        stub = 1'b0;
        s0   = start_cnt;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checkOutput("post_rst_no_valid", seen, 0);
        checkOutput("post_rst_no_start", start_cnt - s0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
